cacheline_adaptor: RTL and testbench

- Memory-side responder for the cache's physical-memory port.
- Accepts one 256-bit cacheline read or write request from the cache: pmem_address, pmem_read, pmem_write, pmem_wdata in; pmem_rdata, pmem_resp out.
- Converts each request into a 4-beat, 64-bit burst transaction on the main-memory interface.
- Sits between the cache datapath/control and the burst memory model (or DRAM controller).

---
 rtl/cacheline_adaptor.sv | 133 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - cacheline to 4-beat memory burst adaptor
module cacheline_adaptor #(
    parameter int s_line    = 256,
    parameter int s_burst   = 64,
    parameter int num_beats = s_line / s_burst
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [s_line-1:0]    line_i,
    output logic [s_line-1:0]    line_o,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    output logic                 resp_o,
    input  logic [s_burst-1:0]   burst_i,
    output logic [s_burst-1:0]   burst_o,
    output logic [31:0]          address_o,
    output logic                 read_o,
    output logic                 write_o,
    input  logic                 resp_i
);

    localparam int CW = (num_beats > 1) ? $clog2(num_beats) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(num_beats - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [s_line-1:0]   r_wbuf;
    logic [s_line-1:0]   r_line;
    logic [31:0]         r_addr;
    logic [31:0]         w_addr_aligned;
    logic                w_last_beat;
    logic                w_unused_addr_bits;

    // Offset bits inside the line never reach memory; bursts are always line-aligned.
    assign w_addr_aligned     = {address_i[31:5], 5'b0};
    assign w_unused_addr_bits = ^address_i[4:0];
    assign w_last_beat        = resp_i && (r_cnt == LAST_BEAT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; write wins when the cache raises both requests
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_next = WRITE;
                end else if (read_i) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            WRITE: begin
                if (w_last_beat) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request capture, beat counting and read-line assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wbuf <= '0;
            r_line <= '0;
            r_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_i) begin
                        r_wbuf <= line_i;
                        r_addr <= w_addr_aligned;
                        r_cnt  <= '0;
                    end else if (read_i) begin
                        r_addr <= w_addr_aligned;
                        r_cnt  <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[r_cnt*s_burst +: s_burst] <= burst_i;
                        if (r_cnt != LAST_BEAT) begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                WRITE: begin
                    if (resp_i && (r_cnt != LAST_BEAT)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never directly on inputs
    assign read_o    = (r_state == READ);
    assign write_o   = (r_state == WRITE);
    assign resp_o    = (r_state == DONE);
    assign address_o = r_addr;
    assign line_o    = r_line;
    assign burst_o   = r_wbuf[r_cnt*s_burst +: s_burst];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks;
    int errors;
    logic [255:0] last_line;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Cache read: request at current negedge, memory returns beats of data
    task automatic do_read(input logic [31:0] a, input logic [255:0] data, input int stall_pct);
        logic [31:0] ea;
        int k;
        int cyc;
        logic r;
        ea = {a[31:5], 5'b0};
        address_i = a;
        read_i    = 1'b1;
        write_i   = 1'b0;
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            chk("rd_read_o", 256'(read_o), 256'(1));
            chk("rd_write_o", 256'(write_o), 256'(0));
            chk("rd_resp_o", 256'(resp_o), 256'(0));
            chk("rd_address_o", 256'(address_o), 256'(ea));
            address_i = $urandom;
            r = ($urandom_range(99) >= stall_pct);
            resp_i  = r;
            burst_i = r ? data[k*64 +: 64] : {$urandom, $urandom};
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        chk("rd_beats", 256'(k), 256'(4));
        resp_i = 1'b0;
        chk("rd_done_resp", 256'(resp_o), 256'(1));
        chk("rd_done_read_o", 256'(read_o), 256'(0));
        chk("rd_done_write_o", 256'(write_o), 256'(0));
        chk("rd_line_o", line_o, data);
        read_i = 1'b0;
        last_line = data;
        @(negedge clk);
        chk("rd_resp_single", 256'(resp_o), 256'(0));
        chk("rd_idle_read_o", 256'(read_o), 256'(0));
    endtask

    // Cache write; pat supplies the first patlen resp_i values, then random stalls
    task automatic do_write(input logic [31:0] a, input logic [255:0] data, input int stall_pct,
                            input logic both, input logic [15:0] pat, input int patlen);
        logic [31:0] ea;
        int k;
        int cyc;
        logic r;
        ea = {a[31:5], 5'b0};
        line_i    = data;
        address_i = a;
        write_i   = 1'b1;
        read_i    = both;
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 100) begin
            chk("wr_write_o", 256'(write_o), 256'(1));
            chk("wr_read_o", 256'(read_o), 256'(0));
            chk("wr_resp_o", 256'(resp_o), 256'(0));
            chk("wr_address_o", 256'(address_o), 256'(ea));
            chk("wr_burst_o", 256'(burst_o), 256'(data[k*64 +: 64]));
            line_i    = rand256();
            address_i = $urandom;
            if (cyc < patlen) r = pat[cyc];
            else r = ($urandom_range(99) >= stall_pct);
            resp_i  = r;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
            if (r) k++;
            cyc++;
        end
        chk("wr_beats", 256'(k), 256'(4));
        resp_i = 1'b0;
        chk("wr_done_resp", 256'(resp_o), 256'(1));
        chk("wr_done_write_o", 256'(write_o), 256'(0));
        chk("wr_done_read_o", 256'(read_o), 256'(0));
        chk("wr_line_o_kept", line_o, last_line);
        write_i = 1'b0;
        read_i  = 1'b0;
        @(negedge clk);
        chk("wr_resp_single", 256'(resp_o), 256'(0));
        chk("wr_idle_write_o", 256'(write_o), 256'(0));
    endtask

    initial begin
        logic [255:0] d;
        checks    = 0;
        errors    = 0;
        last_line = '0;
        rst       = 1'b1;
        line_i    = '0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        burst_i   = '0;
        resp_i    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_line_o", line_o, 256'(0));
        chk("rst_address_o", 256'(address_o), 256'(0));
        chk("rst_burst_o", 256'(burst_o), 256'(0));
        chk("rst_read_o", 256'(read_o), 256'(0));
        chk("rst_write_o", 256'(write_o), 256'(0));
        chk("rst_resp_o", 256'(resp_o), 256'(0));
        rst = 1'b0;

        // Directed read, no stalls
        d = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_read(32'h0000_1234, d, 0);

        // Spurious memory handshakes while idle
        resp_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_read_o", 256'(read_o), 256'(0));
            chk("idle_write_o", 256'(write_o), 256'(0));
            chk("idle_resp_o", 256'(resp_o), 256'(0));
            chk("idle_line_o", line_o, last_line);
        end
        resp_i = 1'b0;

        // Directed write with resp_i pattern 1,0,0,1,1,0,1
        do_write(32'h8000_0040, rand256(), 0, 1'b0, 16'b0000_0000_0101_1001, 7);

        // Simultaneous read and write request
        do_write($urandom, rand256(), 0, 1'b1, 16'h0, 0);

        // Back-to-back: read, then write raised the cycle after resp_o
        do_read($urandom, rand256(), 20);
        do_write($urandom, rand256(), 20, 1'b0, 16'h0, 0);

        // Reset in the middle of a read after two beats
        address_i = 32'h0000_2000;
        read_i    = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            @(negedge clk);
        end
        chk("mid_read_o", 256'(read_o), 256'(1));
        rst     = 1'b1;
        resp_i  = 1'b0;
        read_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_read_o", 256'(read_o), 256'(0));
        chk("abort_resp_o", 256'(resp_o), 256'(0));
        chk("abort_line_o", line_o, 256'(0));
        chk("abort_address_o", 256'(address_o), 256'(0));
        last_line = '0;
        @(negedge clk);
        chk("abort_no_resp", 256'(resp_o), 256'(0));
        do_read($urandom, rand256(), 0);

        // Randomized mix of transactions with random stalls
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1) == 0) do_read($urandom, rand256(), 35);
            else do_write($urandom, rand256(), 35, 1'($urandom_range(1)), 16'h0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
